// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: normalised (active-high) patterns, bit6=g .. bit0=a,
// digit slot indices and the special nibbles used by the scan decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int unsigned IDX_SECR = 0;
  localparam int unsigned IDX_SECL = 1;
  localparam int unsigned IDX_MINR = 2;
  localparam int unsigned IDX_MINL = 3;

  localparam logic [3:0] NIB_ERR   = 4'hE;
  localparam logic [3:0] NIB_BLANK = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD nibble decode. Blank decodes to NIB_BLANK
// and is valid; any unknown pattern yields NIB_ERR with valid low.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = NIB_ERR;
    valid  = 1'b1;
    case (seg)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_BLANK: nibble = NIB_BLANK;
      default:   valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed seven-segment bus, captures each settled digit dwell and
// assembles complete 4-digit frames {MinL,MinR,SecL,SecR}.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  anode,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        anode_err
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [10:0] in_n;
  logic [10:0] s;
  logic [7:0]  stable_cnt;
  logic [3:0]  mask;
  logic        err_acc;
  logic [15:0] asm_buf;
  logic [15:0] new_buf;
  logic        settle;
  logic [3:0]  s_an;
  logic        multi;
  logic        one_hot;
  logic [1:0]  idx;
  logic [3:0]  bitv;
  logic [3:0]  dec_nib;
  logic        dec_ok;

  assign in_n = ACTIVE_LOW ? ~{anode, seg} : {anode, seg};

  // The dwell is identical in s and the input at the settle edge, so the registered
  // copy is decoded, keeping the decoder off the raw input path.
  assign settle = (in_n == s) && (stable_cnt == SETTLE - 8'd1);
  assign s_an   = s[10:7];

  seg7_to_bcd u_dec (
    .seg    (s[6:0]),
    .nibble (dec_nib),
    .valid  (dec_ok)
  );

  always_comb begin
    multi   = (s_an & (s_an - 4'd1)) != '0;
    one_hot = (s_an != '0) && !multi;
    idx     = '0;
    case (s_an)
      4'b0001: idx = 2'(IDX_SECR);
      4'b0010: idx = 2'(IDX_SECL);
      4'b0100: idx = 2'(IDX_MINR);
      4'b1000: idx = 2'(IDX_MINL);
      default: idx = '0;
    endcase
    bitv    = 4'b0001 << idx;
    new_buf = asm_buf;
    new_buf[{idx, 2'b00} +: 4] = dec_nib;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s           <= '0;
      stable_cnt  <= '0;
      mask        <= '0;
      err_acc     <= 1'b0;
      asm_buf     <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      s <= in_n;
      if (in_n == s) begin
        if (stable_cnt != SETTLE) stable_cnt <= stable_cnt + 8'd1;
      end else begin
        stable_cnt <= '0;
      end

      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      anode_err   <= 1'b0;

      if (settle) begin
        if (one_hot) begin
          asm_buf <= new_buf;
          if ((mask | bitv) == 4'hF) begin
            digits      <= new_buf;
            frame_valid <= 1'b1;
            frame_err   <= err_acc | ~dec_ok;
            mask        <= '0;
            err_acc     <= 1'b0;
          end else begin
            mask    <= mask | bitv;
            err_acc <= err_acc | ~dec_ok;
          end
        end else if (multi) begin
          anode_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the stopwatch display driver.
- Samples the multiplexed seven-segment bus (seg/anode), waits for each digit dwell to settle, decodes the segment pattern back to a BCD digit, and assembles complete 4-digit frames (MinL MinR : SecL SecR).
- Used as a synthesizable loopback monitor and as the self-checking scoreboard front end in top-level benches.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical samples required before a dwell is captured (legal range 1..255).
- ACTIVE_LOW, 1, 1 = seg and anode inputs are active-low (board polarity); 0 = active-high.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- seg  input  7  segment lines, bit0=a … bit6=g.
- anode  input  4  digit enables; anode[0]=SecR, [1]=SecL, [2]=MinR, [3]=MinL.
- digits  output  16  last complete frame, {MinL,MinR,SecL,SecR}, 4-bit BCD each.
- frame_valid  output  1  one-cycle pulse; digits updated this cycle.
- frame_err  output  1  qualified by frame_valid; at least one digit in the frame was undecodable.
- anode_err  output  1  one-cycle pulse; a settled dwell had more than one anode active.

Behaviour:
- Normalisation: if ACTIVE_LOW=1, invert seg and anode before any other use.
- Sample register s = {anode,seg}, 11 bits. On each edge:
  - if input == s, stable_cnt increments, saturating at SETTLE_CYCLES;
  - otherwise stable_cnt is cleared to 0.
  - s is loaded with the input on every edge.
- Settle event: occurs on the edge where stable_cnt goes from SETTLE_CYCLES-1 to SETTLE_CYCLES.
  - At most one event per dwell, guaranteed by saturation.
  - With inputs changing after edge E0 and then held, the event is at edge E0+SETTLE_CYCLES+1.
- Action at the settle event, based on the normalised anode:
  - Exactly one bit set: decode seg, write the nibble to assembly slot idx, set mask[idx]. Undecodable pattern writes nibble 0xE and sets err_acc.
  - All zero: blanking interval. No capture, no error.
  - Two or more bits set: no capture; anode_err pulses high the following cycle.
- Decode table (normalised, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - blank 0000000 → 0xF, not an error.
  - Any other pattern is an error.
- Capture into an already-set slot overwrites it; the latest value wins.
- Frame completion: at a capture edge where (mask | bit) == 4'hF:
  - digits <= assembled value including this capture;
  - frame_valid <= 1 and frame_err <= err_acc | this_err;
  - mask <= 0 and err_acc <= 0, all at the same edge;
  - frame_valid and frame_err are high for the following cycle only.
- Dwells shorter than SETTLE_CYCLES+1 cycles are ignored entirely (glitch rejection).
- Dwell state machine: IDLE (stable_cnt<SETTLE) → CAPTURED (saturated) → IDLE on any input change. Implemented implicitly by stable_cnt; no separate state register is required.
- Reset, including mid-frame: s, stable_cnt, mask, err_acc, digits, frame_valid, frame_err and anode_err all clear to 0. The next frame requires four fresh captures.
- No output is combinational from an input.

Decomposition:
- Package seg7_pkg:
  - ten digit pattern constants, SEG_BLANK;
  - digit index constants IDX_SECR..IDX_MINL;
  - error nibble 4'hE and blank nibble 4'hF.
- Sub-module seg7_to_bcd: combinational pattern-to-nibble decode with a valid flag. It is shared with future display checkers.
- Stability counter, assembly buffer and frame logic stay in seg_scan_decoder.

Test Plan:
- Scan "12:34" (ACTIVE_LOW=1, 16 clocks/digit, anode order 0→3, 2 blanking clocks between digits) → frame_valid every 72 clocks, digits=16'h1234, frame_err=0, anode_err never high.
- Insert a 3-cycle (< SETTLE_CYCLES+1) pattern "8" on anode[1] between dwells → ignored; digits still 16'h1234.
- Drive seg pattern 1000000 (segment g only) for SecL → frame completes with digits=16'h12E4 and frame_err=1; the next clean frame has frame_err=0.
- Hold anode=4'b0011 (normalised) for 16 clocks → exactly one anode_err pulse, mask unchanged, no frame_valid.
- Capture MinL and MinR, assert reset for 1 cycle, then scan a full "05:59" → digits=16'h0559 only after all four new dwells, with no frame_valid before that.
- MinL blank pattern with "9:07" on the other slots → digits=16'hF907, frame_err=0.
